store_rmw_unit: RTL
===================

STORE_RMW_UNIT -- requirements
Module: store_rmw_unit

Interface
REQ-001 The block SHALL have parameter READ_LAT, default 1, meaning memory read latency in cycles (legal 1..4).
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  store request; sampled only in IDLE.
REQ-005 addr  input  32  byte address of the store.
REQ-006 wdata  input  32  store data, right-aligned (sb uses [7:0], sh uses [15:0]).
REQ-007 size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 misaligned  output  1  one-cycle error pulse, coincident with done.
REQ-011 mem_addr  output  32  word address {addr_q[31:2],2'b00}.
REQ-012 mem_re  output  1  memory read strobe.
REQ-013 mem_rdata  input  32  memory read data, valid READ_LAT cycles after the mem_re cycle.
REQ-014 mem_we  output  1  memory write strobe.
REQ-015 mem_wdata  output  32  merged full word to write.

Function
REQ-016 The FSM SHALL have the states IDLE, CHECK, READ, WAIT and WRITE.
REQ-017 In IDLE with start=1 the block SHALL register addr, wdata and size and go to CHECK; start SHALL be ignored in all other states.
REQ-018 The CHECK state SHALL flag a misalignment when the request is half with addr_q[0]=1, word with addr_q[1:0]!=0, or size=11.
REQ-019 On a misalignment, CHECK SHALL pulse done and misaligned, issue no memory access, and return to IDLE.
REQ-020 On an aligned word request, CHECK SHALL go to WRITE (no read).
REQ-021 On an aligned byte or half request, CHECK SHALL go to READ.
REQ-022 READ SHALL assert mem_re for exactly one cycle, then go to WAIT.
REQ-023 WAIT SHALL count READ_LAT cycles from the mem_re cycle, capture mem_rdata in the cycle it becomes valid, then go to WRITE.
REQ-024 WRITE SHALL assert mem_we and done for exactly one cycle, then go to IDLE.
REQ-025 The merge SHALL work on the captured word as follows:
- byte, lane k = addr_q[1:0]: bits [8k+7:8k] = wdata_q[7:0];
- half, lane h = addr_q[1]: bits [16h+15:16h] = wdata_q[15:0];
- word: mem_wdata = wdata_q;
- all other bits unchanged.
REQ-026 mem_addr SHALL stay stable from CHECK through WRITE.
REQ-027 mem_re and mem_we SHALL never be high in the same cycle.
REQ-028 Latency from the start cycle T SHALL be:
- aligned word: WRITE/done at T+2;
- byte/half: READ at T+2, WRITE/done at T+3+READ_LAT;
- misaligned: done at T+1.
REQ-029 A new start SHALL be accepted in the IDLE cycle that follows WRITE.

Reset
REQ-030 On reset, state SHALL be IDLE and busy, done, misaligned, mem_re and mem_we SHALL be 0.
REQ-031 On reset, mem_addr, mem_wdata and the captured registers SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL abort with no mem_we issued; the cycle after the reset edge SHALL be IDLE with all strobes low.
REQ-033 Reset SHALL override a coincident start.

Structure
REQ-034 A shared package SHALL hold the size encoding enum (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-035 The lane merge SHALL be a combinational sub-module named store_lane_merge (inputs: old word, data, size, addr[1:0]; output: merged word).

Verification
REQ-036 sb: addr=0x103, wdata=0xAB, rdata=0x11223344 -> one mem_re at 0x100, then mem_we with mem_wdata=0xAB223344, done at T+4 (READ_LAT=1).
REQ-037 sh: addr=0x202, wdata=0xBEEF, rdata=0xAAAAAAAA -> mem_wdata=0xBEEFAAAA.
REQ-038 sw: addr=0x300, wdata=0xDEADBEEF -> no mem_re, mem_we at T+2 with 0xDEADBEEF.
REQ-039 sh at 0x201, and sw at 0x302 -> done and misaligned pulsed at T+1; mem_re and mem_we never asserted.
REQ-040 Reset asserted during WAIT of an sb -> no mem_we, busy=0 next cycle; a following sw completes normally.
REQ-041 READ_LAT=3, sb at addr=0x101 -> WRITE at T+6; start pulses while busy are ignored (exactly one mem_we).

Source files
------------

// File: rtl/store_rmw_unit_pkg.sv
// Shared types for the store read-modify-write unit.
//   size_e  : store size encoding (byte / half / word / illegal)
//   state_e : control FSM states
//   req_t   : request fields captured at start
package store_rmw_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        WRITE = 3'd4
    } state_e;

    typedef struct packed {
        size_e             size;
        logic [1:0]        lo;
        logic [DATA_W-1:0] data;
    } req_t;

    // Half needs bit 0 clear, word needs both low bits clear, illegal size always faults.
    function automatic logic is_misaligned(size_e sz, logic [1:0] lo);
        logic r;
        case (sz)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = lo[0];
            SZ_WORD: r = (lo != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: overlays right-aligned store data onto an old word.
//   old_word : word read from memory
//   data     : right-aligned store data
//   size     : store size
//   lo       : byte offset within the word
//   merged   : resulting word to write back
module store_lane_merge
    import store_rmw_unit_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] data,
    input  size_e             size,
    input  logic [1:0]        lo,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{lo, 3'b000} +: 8] = data[7:0];
            SZ_HALF: begin
                if (lo[1]) merged[31:16] = data[15:0];
                else       merged[15:0]  = data[15:0];
            end
            SZ_WORD: merged = data;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit that turns sub-word stores into read-modify-write word accesses.
//   clk, reset      : clock, synchronous active-high reset
//   start           : store request (accepted in IDLE only)
//   addr/wdata/size : store byte address, right-aligned data, size code
//   busy            : high whenever not IDLE
//   done/misaligned : completion pulse / error pulse (coincident with done)
//   mem_*           : word-wide memory port, read data valid READ_LAT cycles after mem_re
module store_rmw_unit
    import store_rmw_unit_pkg::*;
#(
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        size,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata
);

    state_e            state, state_n;
    req_t              req_q;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              load_c;
    logic              mis_in_c;
    logic              mis_q_c;
    logic [DATA_W-1:0] merged_c;
    logic              busy_n, done_n, mis_n, re_n, we_n;
    logic [DATA_W-1:0] wdata_n;

    // Old word is taken straight from the read port; it is only consumed in the
    // cycle the read data is valid (or ignored entirely for a full-word store).
    store_lane_merge u_merge (
        .old_word (mem_rdata),
        .data     (req_q.data),
        .size     (req_q.size),
        .lo       (req_q.lo),
        .merged   (merged_c)
    );

    // State, request capture and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_q      <= '0;
            cnt_q      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt_q      <= cnt_n;
            mem_wdata  <= wdata_n;
            busy       <= busy_n;
            done       <= done_n;
            misaligned <= mis_n;
            mem_re     <= re_n;
            mem_we     <= we_n;
            if (load_c) begin
                req_q.size <= size_e'(size);
                req_q.lo   <= addr[1:0];
                req_q.data <= wdata;
                mem_addr   <= {addr[ADDR_W-1:2], 2'b00};
            end
        end
    end

    // Next state; outputs are derived from the next state so they are registered
    // yet line up with the state they belong to.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt_q;
        wdata_n  = mem_wdata;
        load_c   = 1'b0;
        mis_in_c = is_misaligned(size_e'(size), addr[1:0]);
        mis_q_c  = is_misaligned(req_q.size, req_q.lo);

        case (state)
            IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (mis_q_c)                    state_n = IDLE;
                else if (req_q.size == SZ_WORD) state_n = WRITE;
                else                            state_n = READ;
            end
            READ: begin
                state_n = WAIT;
                cnt_n   = CNT_W'(1);
            end
            WAIT: begin
                if (cnt_q == CNT_W'(READ_LAT)) state_n = WRITE;
                else                           cnt_n   = cnt_q + CNT_W'(1);
            end
            WRITE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
        re_n   = (state_n == READ);
        we_n   = (state_n == WRITE);
        // Misalignment is known from the raw request so the pulse lands in CHECK.
        mis_n  = load_c && mis_in_c;
        done_n = we_n || mis_n;
        if (we_n) wdata_n = merged_c;
    end

endmodule
